decode_seq: RTL and testbench

DECODE_SEQ -- requirements
Module: decode_seq

---
 rtl/decode_seq_if.sv | 27 ++
 rtl/decode_seq.sv | 98 +++++++++
 tb/tb_decode_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/decode_seq_if.sv
// Command/decode bundle for decode_seq.
// The master issues commands; the slave returns the one-hot decode and status.
interface decode_seq_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 2 ** SEL_W;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [SEL_W-1:0] a;
    logic [OUT_W-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             out_valid;
    logic             busy;
    logic             wrap;

    modport master (
        output in_valid, mode, a,
        input  in_ready, y, idx, out_valid, busy, wrap
    );

    modport slave (
        input  in_valid, mode, a,
        output in_ready, y, idx, out_valid, busy, wrap
    );
endinterface

// File: rtl/decode_seq.sv
// Registered one-hot decoder with CLEAR/LOAD/STEP/SWEEP commands.
// A SWEEP walks the hot bit up to the MSB, blocking new commands meanwhile.
module decode_seq #(
    parameter int SEL_W = 3
) (
    input logic        clk,
    input logic        rst_n,
    decode_seq_if.slave bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [OUT_W-1:0] ONE = OUT_W'(1);
    localparam logic [SEL_W-1:0] INC = SEL_W'(1);
    localparam logic [SEL_W-1:0] TOP = '1;

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } st_e;

    st_e              st;
    logic [OUT_W-1:0] y_q;
    logic [SEL_W-1:0] idx_q;
    logic             ov_q;
    logic             wrap_q;

    logic acc;
    logic is_clr;
    logic is_ld;
    logic is_stp;
    logic is_swp;

    assign acc    = bus.in_valid && (st == S_IDLE);
    assign is_clr = (bus.mode == 2'b00);
    assign is_ld  = (bus.mode == 2'b01);
    assign is_stp = (bus.mode == 2'b10);
    assign is_swp = (bus.mode == 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= S_IDLE;
            y_q    <= '0;
            idx_q  <= '0;
            ov_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (st == S_SWEEP) begin
                // Leave the sweep in the same edge the MSB becomes hot
                y_q   <= y_q << 1;
                idx_q <= idx_q + INC;
                if (y_q[OUT_W-2]) begin
                    st <= S_IDLE;
                end
            end else if (acc) begin
                unique case (1'b1)
                    is_clr: begin
                        y_q   <= '0;
                        idx_q <= '0;
                        ov_q  <= 1'b0;
                    end
                    is_ld: begin
                        y_q   <= ONE << bus.a;
                        idx_q <= bus.a;
                        ov_q  <= 1'b1;
                    end
                    is_stp: begin
                        ov_q <= 1'b1;
                        if (y_q == '0) begin
                            y_q   <= ONE;
                            idx_q <= '0;
                        end else begin
                            y_q    <= {y_q[OUT_W-2:0], y_q[OUT_W-1]};
                            idx_q  <= idx_q + INC;
                            wrap_q <= y_q[OUT_W-1];
                        end
                    end
                    is_swp: begin
                        y_q   <= ONE << bus.a;
                        idx_q <= bus.a;
                        ov_q  <= 1'b1;
                        if (bus.a != TOP) begin
                            st <= S_SWEEP;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = (st == S_IDLE);
    assign bus.y         = y_q;
    assign bus.idx       = idx_q;
    assign bus.out_valid = ov_q;
    assign bus.busy      = (st == S_SWEEP);
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: directed vector table, corner sequences,
// and random commands against an index/countdown reference model.
module tb_decode_seq;
    logic clk;
    logic rst_n;

    decode_seq_if #(.SEL_W(3)) tif ();

    decode_seq #(.SEL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // Reference model: hot position (-1 = none) and remaining sweep cycles
    int m_pos;
    int m_rem;
    bit m_wrap;

    typedef struct {
        bit         v;
        logic [1:0] m;
        logic [2:0] a;
        logic [7:0] ey;
        logic [2:0] eidx;
        bit         eov;
        bit         ebusy;
        bit         ewrap;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] m_y();
        logic [7:0] one;
        one = 8'd1;
        return (m_pos < 0) ? 8'd0 : (one << m_pos);
    endfunction

    task automatic m_reset();
        m_pos  = -1;
        m_rem  = 0;
        m_wrap = 0;
    endtask

    task automatic m_edge(input bit v, input logic [1:0] m, input int a);
        m_wrap = 0;
        if (m_rem > 0) begin
            m_pos++;
            m_rem--;
        end else if (v) begin
            case (m)
                2'b00: m_pos = -1;
                2'b01: m_pos = a;
                2'b10: begin
                    if (m_pos < 0) m_pos = 0;
                    else begin
                        m_wrap = (m_pos == 7);
                        m_pos  = (m_pos + 1) % 8;
                    end
                end
                default: begin
                    m_pos = a;
                    m_rem = 7 - a;
                end
            endcase
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".y"}, 32'(tif.y), 32'(m_y()));
        chk({tag, ".idx"}, 32'(tif.idx), 32'((m_pos < 0) ? 0 : m_pos));
        chk({tag, ".ov"}, 32'(tif.out_valid), 32'(m_pos >= 0));
        chk({tag, ".busy"}, 32'(tif.busy), 32'(m_rem > 0));
        chk({tag, ".rdy"}, 32'(tif.in_ready), 32'(m_rem == 0));
        chk({tag, ".wrap"}, 32'(tif.wrap), 32'(m_wrap));
    endtask

    task automatic cyc(input bit v, input logic [1:0] m, input logic [2:0] a);
        tif.in_valid = v;
        tif.mode     = m;
        tif.a        = a;
        @(posedge clk);
        #1;
        m_edge(v, m, int'(a));
    endtask

    task automatic do_reset();
        tif.in_valid = 1'b0;
        tif.mode     = 2'b00;
        tif.a        = 3'd0;
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        #2;
        chk("rst.y", 32'(tif.y), 32'd0);
        chk("rst.busy", 32'(tif.busy), 32'd0);
        chk("rst.rdy", 32'(tif.in_ready), 32'd1);
        chk("rst.ov", 32'(tif.out_valid), 32'd0);
        chk("rst.wrap", 32'(tif.wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b1;
        m_reset();

        for (int i = 0; i < 8; i++)
            tbl.push_back('{1, 2'b01, 3'(i), 8'd1 << i, 3'(i), 1, 0, 0});
        tbl.push_back('{0, 2'b10, 3'd0, 8'h80, 3'd7, 1, 0, 0});
        tbl.push_back('{1, 2'b10, 3'd0, 8'h01, 3'd0, 1, 0, 1});
        tbl.push_back('{1, 2'b10, 3'd0, 8'h02, 3'd1, 1, 0, 0});
        tbl.push_back('{1, 2'b00, 3'd5, 8'h00, 3'd0, 0, 0, 0});
        tbl.push_back('{1, 2'b10, 3'd6, 8'h01, 3'd0, 1, 0, 0});
        tbl.push_back('{0, 2'b01, 3'd6, 8'h01, 3'd0, 1, 0, 0});
        tbl.push_back('{1, 2'b00, 3'd0, 8'h00, 3'd0, 0, 0, 0});

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].v, tbl[i].m, tbl[i].a);
            chk($sformatf("tbl%0d.y", i), 32'(tif.y), 32'(tbl[i].ey));
            chk($sformatf("tbl%0d.idx", i), 32'(tif.idx), 32'(tbl[i].eidx));
            chk($sformatf("tbl%0d.ov", i), 32'(tif.out_valid), 32'(tbl[i].eov));
            chk($sformatf("tbl%0d.busy", i), 32'(tif.busy), 32'(tbl[i].ebusy));
            chk($sformatf("tbl%0d.wrap", i), 32'(tif.wrap), 32'(tbl[i].ewrap));
        end

        // SWEEP a=2 with a LOAD held during the sweep
        cyc(1, 2'b11, 3'd2);
        chk("sw2.y0", 32'(tif.y), 32'h04);
        chk("sw2.b0", 32'(tif.busy), 32'd1);
        begin
            logic [7:0] ys [5];
            ys = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
            for (int k = 0; k < 5; k++) begin
                cyc(1, 2'b01, 3'd1);
                chk($sformatf("sw2.y%0d", k + 1), 32'(tif.y), 32'(ys[k]));
                chk($sformatf("sw2.b%0d", k + 1), 32'(tif.busy), 32'(k < 4));
            end
        end
        cyc(1, 2'b01, 3'd1);
        chk("sw2.ld", 32'(tif.y), 32'h02);
        chk("sw2.ldidx", 32'(tif.idx), 32'd1);

        // SWEEP from the MSB never goes busy
        cyc(1, 2'b11, 3'd7);
        chk("sw7.y", 32'(tif.y), 32'h80);
        chk("sw7.b", 32'(tif.busy), 32'd0);
        chk("sw7.rdy", 32'(tif.in_ready), 32'd1);
        cyc(0, 2'b00, 3'd0);
        chk("sw7.b2", 32'(tif.busy), 32'd0);
        chk("sw7.y2", 32'(tif.y), 32'h80);

        // Async reset in the middle of a sweep
        cyc(1, 2'b11, 3'd0);
        for (int k = 0; k < 3; k++) cyc(0, 2'b00, 3'd0);
        chk("swr.y", 32'(tif.y), 32'h08);
        chk("swr.b", 32'(tif.busy), 32'd1);
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        chk("swr.ry", 32'(tif.y), 32'h00);
        chk("swr.rb", 32'(tif.busy), 32'd0);
        chk("swr.rrdy", 32'(tif.in_ready), 32'd1);
        #2 rst_n = 1'b1;
        cyc(1, 2'b01, 3'd5);
        chk("swr.ld", 32'(tif.y), 32'h20);
        chk("swr.idx", 32'(tif.idx), 32'd5);
        chk_model("swr");

        // Random commands against the model
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 9) < 7), 2'($urandom), 3'($urandom));
            chk_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
